// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for the round-robin Wishbone arbiter: NM master request ports on one
// side and the single shared slave port on the other.
interface wb_rr_arbiter_if #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 128,
  parameter int SW = DW / 8
);
  // Handshake: stb is the per-beat valid; the beat completes on the cycle where
  // stb & (ack | err). cyc frames the whole locked transfer and owns the grant.
  logic [NM*AW-1:0] m_wb_adr;
  logic [NM*SW-1:0] m_wb_sel;
  logic [NM-1:0]    m_wb_we;
  logic [NM*DW-1:0] m_wb_dat_i;
  logic [DW-1:0]    m_wb_dat_o;
  logic [NM-1:0]    m_wb_cyc;
  logic [NM-1:0]    m_wb_stb;
  logic [NM-1:0]    m_wb_ack;
  logic [NM-1:0]    m_wb_err;
  logic [AW-1:0]    s_wb_adr;
  logic [SW-1:0]    s_wb_sel;
  logic             s_wb_we;
  logic [DW-1:0]    s_wb_dat_o;
  logic [DW-1:0]    s_wb_dat_i;
  logic             s_wb_cyc;
  logic             s_wb_stb;
  logic             s_wb_ack;
  logic             s_wb_err;

  // master: the requesting masters plus the shared slave's responses
  modport master (
    output m_wb_adr, m_wb_sel, m_wb_we, m_wb_dat_i, m_wb_cyc, m_wb_stb,
    output s_wb_dat_i, s_wb_ack, s_wb_err,
    input  m_wb_dat_o, m_wb_ack, m_wb_err,
    input  s_wb_adr, s_wb_sel, s_wb_we, s_wb_dat_o, s_wb_cyc, s_wb_stb
  );

  // slave: the arbiter itself
  modport slave (
    input  m_wb_adr, m_wb_sel, m_wb_we, m_wb_dat_i, m_wb_cyc, m_wb_stb,
    input  s_wb_dat_i, s_wb_ack, s_wb_err,
    output m_wb_dat_o, m_wb_ack, m_wb_err,
    output s_wb_adr, s_wb_sel, s_wb_we, s_wb_dat_o, s_wb_cyc, s_wb_stb
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one registered grant held for a master's whole cyc,
// with a stall watchdog that forces err so a dead slave cannot lock the bus.
module wb_rr_arbiter #(
  parameter int NM      = 2,
  parameter int AW      = 32,
  parameter int DW      = 128,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_rr_arbiter_if.slave    bus,
  output logic [NM-1:0]     o_grant,
  output logic              o_timeout,
  output logic [1:0]        o_dbg_state
);
  localparam int LW = (NM > 1) ? $clog2(NM) : 1;
  localparam int WW = $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [LW-1:0] last_q, last_d;
  logic [WW-1:0] wdog_q, wdog_d;

  logic          busy;
  logic          g_cyc;
  logic          g_stb;
  logic          expire;
  logic          found;
  logic [LW-1:0] winner;
  int            arb_idx;

  // last_q doubles as the granted master index whenever a grant is live
  assign busy   = (state_q == ST_BUSY);
  assign g_cyc  = bus.m_wb_cyc[last_q];
  assign g_stb  = busy & bus.m_wb_stb[last_q];
  assign expire = g_stb & ~bus.s_wb_ack & ~bus.s_wb_err & (wdog_q == WW'(TIMEOUT - 1));

  always_comb begin
    bus.s_wb_adr   = '0;
    bus.s_wb_sel   = '0;
    bus.s_wb_we    = 1'b0;
    bus.s_wb_dat_o = '0;
    bus.s_wb_cyc   = 1'b0;
    bus.s_wb_stb   = 1'b0;
    bus.m_wb_ack   = '0;
    bus.m_wb_err   = '0;
    bus.m_wb_dat_o = bus.s_wb_dat_i;
    if (busy) begin
      bus.s_wb_adr   = bus.m_wb_adr[int'(last_q)*AW +: AW];
      bus.s_wb_sel   = bus.m_wb_sel[int'(last_q)*SW +: SW];
      bus.s_wb_we    = bus.m_wb_we[last_q];
      bus.s_wb_dat_o = bus.m_wb_dat_i[int'(last_q)*DW +: DW];
      bus.s_wb_cyc   = g_cyc;
      bus.s_wb_stb   = g_stb;
      bus.m_wb_ack   = NM'(bus.s_wb_ack) << last_q;
      bus.m_wb_err   = NM'(bus.s_wb_err | expire) << last_q;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = '0;
    found   = 1'b0;
    winner  = '0;
    arb_idx = 0;
    // scan last+1 .. last+NM so the previous owner is considered last
    for (int i = 1; i <= NM; i++) begin
      arb_idx = (int'(last_q) + i) % NM;
      if (!found && bus.m_wb_cyc[arb_idx[LW-1:0]]) begin
        found  = 1'b1;
        winner = arb_idx[LW-1:0];
      end
    end
    if (state_q == ST_IDLE || !g_cyc) begin
      if (found) begin
        state_d = ST_BUSY;
        grant_d = NM'(1) << winner;
        last_d  = winner;
      end else begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    end else if (expire) begin
      state_d = ST_ERR;
    end else if (g_stb && !bus.s_wb_ack && !bus.s_wb_err) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LW'(NM - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_timeout   = expire;
  assign o_dbg_state = state_q;
endmodule
